// File: rtl/qam_symbol_packer_pkg.sv
// Shared constants for the QAM symbol packer.
// QAM_PACKER_PARITY_EN widens the buffered payload by one parity bit.
package qam_demapper_pkg;

  localparam int BYTE_W    = 8;
  localparam int BUF_DEPTH = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_PACK  = 2'b01,
    ST_FLUSH = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

`ifdef QAM_PACKER_PARITY_EN
  localparam int PAY_W = BYTE_W + 1;
`else
  localparam int PAY_W = BYTE_W;
`endif

  // Left-justify the nbits most recent symbol bits, zero-filling the LSBs.
  function automatic logic [BYTE_W-1:0] pad_partial(
    input logic [BYTE_W-1:0] acc,
    input int                nbits
  );
    return acc << (BYTE_W - nbits);
  endfunction

endpackage

// File: rtl/qam_symbol_packer_if.sv
// Byte output bus of the QAM symbol packer (valid/ready).
// QAM_PACKER_PARITY_EN adds byte_parity alongside byte_out.
interface qam_symbol_packer_if;
  import qam_demapper_pkg::*;

  logic [BYTE_W-1:0] byte_out;
  logic              byte_valid;
  logic              byte_ready;
`ifdef QAM_PACKER_PARITY_EN
  logic              byte_parity;
`endif

  modport master (
    output byte_out,
    output byte_valid,
`ifdef QAM_PACKER_PARITY_EN
    output byte_parity,
`endif
    input  byte_ready
  );

  modport slave (
    input  byte_out,
    input  byte_valid,
`ifdef QAM_PACKER_PARITY_EN
    input  byte_parity,
`endif
    output byte_ready
  );

endinterface

// File: rtl/qam_pack_skid.sv
// Two-entry in-order byte buffer; entry 0 is always the head.
// Payload width follows QAM_PACKER_PARITY_EN through PAY_W.
module qam_pack_skid
  import qam_demapper_pkg::*;
#(
  parameter int W = PAY_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);

  localparam logic [1:0] DEPTH = 2'(BUF_DEPTH);

  logic [W-1:0] e0_q, e0_d;
  logic [W-1:0] e1_q, e1_d;
  logic [1:0]   cnt_q, cnt_d;

  assign dout  = e0_q;
  assign count = cnt_q;
  assign full  = (cnt_q == DEPTH);
  assign empty = (cnt_q == 2'd0);

  // Shift on pop; a simultaneous push refills the freed slot.
  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    cnt_d = cnt_q;
    if (pop && !empty) begin
      e0_d = e1_q;
      if (push) begin
        if (cnt_q == 2'd1) e0_d = din;
        else               e1_d = din;
      end else begin
        cnt_d = cnt_q - 2'd1;
      end
    end else if (push && !full) begin
      if (empty) e0_d = din;
      else       e1_d = din;
      cnt_d = cnt_q + 2'd1;
    end
  end

  // Buffer storage; reset discards any held bytes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= 2'd0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/qam_symbol_packer.sv
// Packs demapped QAM symbols MSB-first into bytes for the host.
// Define QAM_PACKER_PARITY_EN to add even parity on the byte bus.
module qam_symbol_packer
  import qam_demapper_pkg::*;
#(
  parameter int BITS_PER_SYM = 4
) (
  input  logic                    dclk,
  input  logic                    reset,
  input  logic                    available,
  input  logic                    complete,
  input  logic [BITS_PER_SYM-1:0] sym_in,
  input  logic                    sym_valid,
  output logic                    read_enable,
  output logic [15:0]             byte_count,
  output logic                    frame_done,
  qam_symbol_packer_if.master     bus
);

  localparam int         SYMS  = BYTE_W / BITS_PER_SYM;
  localparam logic [1:0] LAST  = 2'(SYMS - 1);
  localparam logic [1:0] DEPTH = 2'(BUF_DEPTH);

  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [BYTE_W-1:0] acc_q, acc_d;
  logic [15:0]       bcnt_q, bcnt_d;
  logic              done_q, done_d;

  logic              accept;
  logic              buf_push, buf_pop;
  logic              buf_full, buf_empty;
  logic [1:0]        buf_count;
  logic [BYTE_W-1:0] full_byte, push_byte;
  logic [PAY_W-1:0]  buf_din, buf_dout;

  assign read_enable    = (state_q == ST_PACK) && (buf_count < DEPTH);
  assign accept         = read_enable && sym_valid;
  assign bus.byte_valid = !buf_empty;
  assign buf_pop        = bus.byte_valid && bus.byte_ready;
  assign full_byte      = {acc_q[BYTE_W-BITS_PER_SYM-1:0], sym_in};
  assign byte_count     = bcnt_q;
  assign frame_done     = done_q;

`ifdef QAM_PACKER_PARITY_EN
  assign buf_din         = {^push_byte, push_byte};
  assign bus.byte_parity = buf_dout[BYTE_W];
`else
  assign buf_din         = push_byte;
`endif
  assign bus.byte_out    = buf_dout[BYTE_W-1:0];

  qam_pack_skid #(.W(PAY_W)) u_skid (
    .clk   (dclk),
    .rst   (reset),
    .push  (buf_push),
    .pop   (buf_pop),
    .din   (buf_din),
    .dout  (buf_dout),
    .full  (buf_full),
    .empty (buf_empty),
    .count (buf_count)
  );

  // Frame sequencing, symbol packing and delivered-byte count.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    bcnt_d    = bcnt_q;
    done_d    = 1'b0;
    buf_push  = 1'b0;
    push_byte = full_byte;
    if (buf_pop && bcnt_q != 16'hFFFF) bcnt_d = bcnt_q + 16'd1;
    unique case (state_q)
      ST_IDLE: begin
        if (available) begin
          state_d = ST_PACK;
          bcnt_d  = 16'd0;
          cnt_d   = 2'd0;
        end
      end
      ST_PACK: begin
        if (accept) begin
          acc_d = full_byte;
          if (cnt_q == LAST) begin
            cnt_d    = 2'd0;
            buf_push = 1'b1;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
        if (complete && !available) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        push_byte = pad_partial(acc_q, int'(cnt_q) * BITS_PER_SYM);
        if (cnt_q != 2'd0) begin
          if (!buf_full) begin
            buf_push = 1'b1;
            cnt_d    = 2'd0;
          end
        end else if (buf_empty) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
    endcase
  end

  // Control state; reset abandons the frame without flushing.
  always_ff @(posedge dclk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 2'd0;
      acc_q   <= '0;
      bcnt_q  <= 16'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      bcnt_q  <= bcnt_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_qam_symbol_packer.sv
// Directed bench for qam_symbol_packer with a queue-based byte model.
// Parity checks are enabled when QAM_PACKER_PARITY_EN is defined.
module tb_qam_symbol_packer;

  logic        dclk = 1'b0;
  logic        reset;
  logic        available, complete, sym_valid;
  logic [3:0]  sym_in;
  logic        read_enable, frame_done;
  logic [15:0] byte_count;

  logic        avail2, comp2, sv2;
  logic [1:0]  sym2;
  logic        re2, fd2;
  logic [15:0] bc2;

  qam_symbol_packer_if bus4();
  qam_symbol_packer_if bus2();

  always #5 dclk = ~dclk;

  qam_symbol_packer #(.BITS_PER_SYM(4)) dut4 (
    .dclk        (dclk),
    .reset       (reset),
    .available   (available),
    .complete    (complete),
    .sym_in      (sym_in),
    .sym_valid   (sym_valid),
    .read_enable (read_enable),
    .byte_count  (byte_count),
    .frame_done  (frame_done),
    .bus         (bus4)
  );

  qam_symbol_packer #(.BITS_PER_SYM(2)) dut2 (
    .dclk        (dclk),
    .reset       (reset),
    .available   (avail2),
    .complete    (comp2),
    .sym_in      (sym2),
    .sym_valid   (sv2),
    .read_enable (re2),
    .byte_count  (bc2),
    .frame_done  (fd2),
    .bus         (bus2)
  );

  int checks, errors;

  logic [7:0] exp_q[$];
  logic [7:0] got[$];
  int         got_cyc[$];
  int         comp_cyc[$];
  bit         got_par[$];
  logic [3:0] part[$];
  int         occ, mcnt, cyc, fd_pulses;
  bit         flushing, in_frame, prev_hold, lat_pending, fd_prev;
  logic [7:0] prev_byte, lat_byte, mb, b2;
  int         gb, cb;
  logic [3:0] s3 [10] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h0,
                          4'h7, 4'h0, 4'h3, 4'h5, 4'h6};

  task automatic chk(input bit ok, input string nm,
                     input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic chk_eq(input string nm,
                        input logic [31:0] act, input logic [31:0] req);
    chk(act === req, nm, act, req);
  endtask

  task automatic chk_got(input string nm, input int idx,
                         input logic [7:0] req);
    if (idx < got.size()) chk_eq(nm, got[idx], req);
    else chk(1'b0, nm, 32'hDEAD, req);
  endtask

  task automatic chk_lat(input string nm, input int gi, input int ci);
    if (gi < got_cyc.size() && ci < comp_cyc.size())
      chk_eq(nm, got_cyc[gi] - comp_cyc[ci], 1);
    else
      chk(1'b0, nm, 0, 1);
  endtask

  task automatic tick();
    @(posedge dclk);
    #1;
  endtask

  task automatic send(input int w, input logic [3:0] s);
    bit taken;
    int n;
    taken = 1'b0;
    n = 0;
    if (w == 0) begin
      sym_in = s;
      sym_valid = 1'b1;
    end else begin
      sym2 = s[1:0];
      sv2 = 1'b1;
    end
    while (!taken && n < 100) begin
      @(negedge dclk);
      taken = (w == 0) ? read_enable : re2;
      tick();
      n++;
    end
    if (!taken) chk(1'b0, "send_timeout", n, 100);
  endtask

  task automatic end_frame(input string nm);
    int base, n;
    base = fd_pulses;
    n = 0;
    available = 1'b0;
    complete = 1'b1;
    while (fd_pulses == base && n < 50) begin
      tick();
      n++;
    end
    if (fd_pulses == base) chk(1'b0, {nm, "_done_timeout"}, n, 50);
    repeat (3) tick();
    chk_eq({nm, "_done_pulses"}, fd_pulses - base, 1);
    complete = 1'b0;
  endtask

  task automatic get2(output logic [7:0] b);
    int n;
    n = 0;
    b = 8'hXX;
    while (n < 30) begin
      @(negedge dclk);
      if (bus2.byte_valid) begin
        b = bus2.byte_out;
        n = 99;
      end else begin
        n++;
      end
    end
    if (n != 99) chk(1'b0, "bps2_byte_timeout", n, 30);
    tick();
  endtask

  initial begin
    checks = 0; errors = 0;
    occ = 0; mcnt = 0; cyc = 0; fd_pulses = 0;
    flushing = 0; in_frame = 0; prev_hold = 0;
    lat_pending = 0; fd_prev = 0;
    prev_byte = 8'h00; lat_byte = 8'h00; mb = 8'h00;
    reset = 1'b1;
    available = 1'b0; complete = 1'b0;
    sym_valid = 1'b0; sym_in = 4'h0;
    bus4.byte_ready = 1'b1;
    avail2 = 1'b0; comp2 = 1'b0; sv2 = 1'b0; sym2 = 2'd0;
    bus2.byte_ready = 1'b1;

    fork
      forever begin
        @(negedge dclk);
        cyc++;
        if (reset) begin
          exp_q.delete();
          part.delete();
          occ = 0; mcnt = 0;
          flushing = 0; in_frame = 0;
          prev_hold = 0; lat_pending = 0; fd_prev = 0;
        end else begin
          chk_eq("byte_count", byte_count, mcnt);
          if (!flushing)
            chk_eq("valid_vs_occupancy", bus4.byte_valid, occ != 0);
          if (lat_pending) begin
            chk_eq("latency_valid", bus4.byte_valid, 1);
            chk_eq("latency_byte", bus4.byte_out, lat_byte);
            lat_pending = 0;
          end
          if (prev_hold) begin
            chk_eq("hold_valid", bus4.byte_valid, 1);
            chk_eq("hold_byte", bus4.byte_out, prev_byte);
          end
          if (read_enable)
            chk_eq("re_needs_space", occ < 2 && !flushing, 1);
          if (frame_done) begin
            chk_eq("done_single", fd_prev, 0);
            chk_eq("done_after_drain", exp_q.size(), 0);
            fd_pulses++;
            in_frame = 0; flushing = 0; occ = 0;
            part.delete();
          end
          fd_prev = frame_done;
          if (bus4.byte_valid && bus4.byte_ready) begin
            if (exp_q.size() == 0) begin
              chk(1'b0, "unexpected_byte", bus4.byte_out, 0);
            end else begin
              mb = exp_q.pop_front();
              chk_eq("byte_order", bus4.byte_out, mb);
            end
`ifdef QAM_PACKER_PARITY_EN
            chk_eq("parity", bus4.byte_parity, ^bus4.byte_out);
            got_par.push_back(bus4.byte_parity);
`endif
            got.push_back(bus4.byte_out);
            got_cyc.push_back(cyc);
            if (mcnt != 65535) mcnt++;
            if (!flushing) occ--;
          end
          prev_hold = bus4.byte_valid && !bus4.byte_ready;
          prev_byte = bus4.byte_out;
          if (read_enable && sym_valid) begin
            part.push_back(sym_in);
            if (part.size() == 2) begin
              mb = {part[0], part[1]};
              part.delete();
              exp_q.push_back(mb);
              comp_cyc.push_back(cyc);
              if (occ == 0) begin
                lat_pending = 1;
                lat_byte = mb;
              end
              occ++;
            end
          end
          if (in_frame && !flushing && complete && !available) begin
            flushing = 1;
            if (part.size() != 0) begin
              mb = {part[0], 4'h0};
              exp_q.push_back(mb);
              part.delete();
            end
          end
          if (!in_frame && available) begin
            in_frame = 1;
            mcnt = 0;
          end
        end
      end
    join_none

    repeat (3) @(posedge dclk);
    #1;
    chk_eq("rst_byte_valid", bus4.byte_valid, 0);
    chk_eq("rst_byte_out", bus4.byte_out, 8'h00);
    chk_eq("rst_read_enable", read_enable, 0);
    chk_eq("rst_byte_count", byte_count, 0);
    chk_eq("rst_frame_done", frame_done, 0);
    reset = 1'b0;
    tick();

    gb = got.size();
    cb = comp_cyc.size();
    available = 1'b1;
    send(0, 4'hA); send(0, 4'h5); send(0, 4'h3); send(0, 4'hC);
    sym_valid = 1'b0;
    repeat (3) tick();
    chk_got("t1_byte0", gb, 8'hA5);
    chk_got("t1_byte1", gb + 1, 8'h3C);
    chk_lat("t1_latency0", gb, cb);
    chk_lat("t1_latency1", gb + 1, cb + 1);
    chk_eq("t1_byte_count", byte_count, 2);
    end_frame("t1");

    gb = got.size();
    available = 1'b1;
    send(0, 4'h1); send(0, 4'h2); send(0, 4'h3);
    sym_valid = 1'b0;
    end_frame("t2");
    chk_eq("t2_nbytes", got.size() - gb, 2);
    chk_got("t2_byte0", gb, 8'h12);
    chk_got("t2_pad", gb + 1, 8'h30);

    gb = got.size();
    available = 1'b1;
    bus4.byte_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++) send(0, s3[i]);
      end
      begin
        repeat (8) @(negedge dclk);
        chk_eq("stall_read_enable", read_enable, 0);
        chk_eq("stall_valid", bus4.byte_valid, 1);
        chk_eq("stall_head", bus4.byte_out, 8'h12);
        repeat (2) tick();
        bus4.byte_ready = 1'b1;
      end
    join
    sym_valid = 1'b0;
    end_frame("t3");
    chk_got("t3_byte0", gb, 8'h12);
    chk_got("t3_byte1", gb + 1, 8'h34);
    chk_got("t3_byte2", gb + 2, 8'h07);
    chk_got("t3_byte3", gb + 3, 8'h03);
    chk_got("t3_byte4", gb + 4, 8'h56);
    chk_eq("t3_byte_count", byte_count, 5);
`ifdef QAM_PACKER_PARITY_EN
    if (gb + 3 < got_par.size()) begin
      chk_eq("parity_07", got_par[gb + 2], 1);
      chk_eq("parity_03", got_par[gb + 3], 0);
    end else begin
      chk(1'b0, "parity_missing", got_par.size(), gb + 4);
    end
`endif

    gb = got.size();
    available = 1'b1;
    bus4.byte_ready = 1'b0;
    send(0, 4'h1); send(0, 4'h2);
    sym_valid = 1'b0;
    chk_eq("pre_rst_valid", bus4.byte_valid, 1);
    #2;
    reset = 1'b1;
    #1;
    chk_eq("mid_rst_byte_valid", bus4.byte_valid, 0);
    chk_eq("mid_rst_byte_out", bus4.byte_out, 8'h00);
    chk_eq("mid_rst_read_enable", read_enable, 0);
    chk_eq("mid_rst_byte_count", byte_count, 0);
    chk_eq("mid_rst_frame_done", frame_done, 0);
    available = 1'b0;
    tick(); tick();
    reset = 1'b0;
    bus4.byte_ready = 1'b1;
    repeat (5) tick();
    chk_eq("no_stale_byte", got.size() - gb, 0);
    chk_eq("post_rst_valid", bus4.byte_valid, 0);

    avail2 = 1'b1;
    send(1, 4'd2); send(1, 4'd1); send(1, 4'd0); send(1, 4'd3);
    sv2 = 1'b0;
    get2(b2);
    chk_eq("bps2_byte", b2, 8'h93);
    send(1, 4'd1); send(1, 4'd2); send(1, 4'd3);
    sv2 = 1'b0;
    avail2 = 1'b0;
    comp2 = 1'b1;
    get2(b2);
    chk_eq("bps2_pad", b2, 8'h6C);
    begin
      int n;
      n = 0;
      while (!fd2 && n < 30) begin
        @(negedge dclk);
        n++;
      end
      chk_eq("bps2_done", fd2, 1);
    end
    tick();
    chk_eq("bps2_byte_count", bc2, 2);
    comp2 = 1'b0;

    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
